// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, stability counter,
// edge pulses, long-press detection and saturating press counters per channel.
module debounce_multi #(
  parameter int N      = 4,
  parameter int STABLE = 8,
  parameter int LONG   = 1000,
  parameter int CTR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i,
  input  logic [N-1:0]     clr,
  output logic [N-1:0]     st_o,
  output logic [N-1:0]     up_o,
  output logic [N-1:0]     dn_o,
  output logic [N-1:0]     lp_o,
  output logic [N*CTR_W-1:0] cnt_o
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int HW = $clog2(LONG + 1);
  localparam logic [SW-1:0]    STAB_MAX = SW'(STABLE - 1);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(LONG);
  localparam logic [HW-1:0]    HOLD_PRE = HW'(LONG - 1);
  localparam logic [CTR_W-1:0] CNT_MAX  = '1;

  logic [N-1:0]     r_s1;
  logic [N-1:0]     r_s2;
  logic [N-1:0]     r_st;
  logic [N-1:0]     r_up;
  logic [N-1:0]     r_dn;
  logic [N-1:0]     r_lp;
  logic [SW-1:0]    r_stab [N];
  logic [HW-1:0]    r_hold [N];
  logic [CTR_W-1:0] r_cnt  [N];

  logic [N-1:0] w_diff;
  logic [N-1:0] w_flip;
  logic [N-1:0] w_rise;
  logic [N-1:0] w_fall;

  always_comb begin
    w_diff = '0;
    w_flip = '0;
    w_rise = '0;
    w_fall = '0;
    for (int k = 0; k < N; k++) begin
      w_diff[k] = r_s2[k] ^ r_st[k];
      w_flip[k] = w_diff[k] && (r_stab[k] == STAB_MAX);
      w_rise[k] = w_flip[k] && !r_st[k];
      w_fall[k] = w_flip[k] && r_st[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_st <= '0;
      r_up <= '0;
      r_dn <= '0;
      r_lp <= '0;
      for (int k = 0; k < N; k++) begin
        r_stab[k] <= '0;
        r_hold[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_s1 <= i;
      r_s2 <= r_s1;
      r_st <= r_st ^ w_flip;
      r_up <= w_rise;
      r_dn <= w_fall;
      for (int k = 0; k < N; k++) begin
        // Any agreement between input and state restarts the qualification window.
        if (!w_diff[k] || w_flip[k])
          r_stab[k] <= '0;
        else
          r_stab[k] <= r_stab[k] + SW'(1);

        if (!r_st[k] || w_fall[k])
          r_hold[k] <= '0;
        else if (r_hold[k] != HOLD_MAX)
          r_hold[k] <= r_hold[k] + HW'(1);

        // Hold counter saturates at LONG, so LONG-1 is seen once per press.
        r_lp[k] <= r_st[k] && !w_fall[k] && (r_hold[k] == HOLD_PRE);

        if (clr[k])
          r_cnt[k] <= '0;
        else if (w_rise[k] && (r_cnt[k] != CNT_MAX))
          r_cnt[k] <= r_cnt[k] + CTR_W'(1);
      end
    end
  end

  assign st_o = r_st;
  assign up_o = r_up;
  assign dn_o = r_dn;
  assign lp_o = r_lp;

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < N; k++) cnt_o[k*CTR_W +: CTR_W] = r_cnt[k];
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N, default 4: number of independent input channels, 1..32.
REQ-002 Parameter STABLE, default 8: consecutive cycles a synchronised input must differ from the debounced state before that state flips, 2..65535.
REQ-003 Parameter LONG, default 1000: cycles the debounced state must stay high before a long-press pulse fires; LONG > STABLE.
REQ-004 Parameter CTR_W, default 16: width of each per-channel press counter.
REQ-005 clk  in  1  single system clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 i  in  N  raw asynchronous button/contact lines, one bit per channel.
REQ-008 clr  in  N  synchronous per-channel press-counter clear.
REQ-009 st_o  out  N  debounced level per channel.
REQ-010 up_o  out  N  one-cycle pulse on a debounced rising transition.
REQ-011 dn_o  out  N  one-cycle pulse on a debounced falling transition.
REQ-012 lp_o  out  N  one-cycle long-press pulse.
REQ-013 cnt_o  out  N*CTR_W  press counters; channel k occupies bits [k*CTR_W +: CTR_W].

Function
REQ-014 Each i[k] SHALL pass through a 2-flop synchroniser; only the second flop output (s[k]) feeds channel logic.
REQ-015 Each channel SHALL hold a stability counter of width clog2(STABLE+1) and a state bit driving st_o[k].
REQ-016 s[k] == st_o[k]: stability counter SHALL clear to 0 on that edge.
REQ-017 s[k] != st_o[k] with counter < STABLE-1: counter SHALL increment.
REQ-018 s[k] != st_o[k] with counter == STABLE-1: st_o[k] SHALL invert, counter SHALL clear, and up_o[k] (new level 1) or dn_o[k] (new level 0) SHALL be high for exactly that one cycle, aligned with the new st_o[k].
REQ-019 Latency: a clean level change on i[k] SHALL appear on st_o[k] at rising edge STABLE+2, counting the first edge that samples the new level as edge 1.
REQ-020 Any single cycle of s[k] == st_o[k] during counting SHALL restart the count from 0; pulses shorter than STABLE cycles after synchronisation never propagate.
REQ-021 up_o[k] and dn_o[k] SHALL never be high in the same cycle; consecutive pulses on a channel SHALL be at least STABLE cycles apart.
REQ-022 Each channel SHALL hold a hold counter, cleared on the up_o[k] cycle and incrementing each cycle while st_o[k]=1, saturating at LONG.
REQ-023 lp_o[k] SHALL pulse for one cycle when the hold counter reaches LONG, once per press; no repeat while held; a falling transition before LONG produces no pulse.
REQ-024 Press counter SHALL increment by 1 on each up_o[k] cycle and saturate at 2^CTR_W-1 (no wrap).
REQ-025 clr[k] SHALL set counter k to 0 on that edge and take priority over a simultaneous increment (result 0); clr does not affect st_o, up_o, dn_o, lp_o.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels are all honoured in the same cycle.

Reset
REQ-027 rst=1 SHALL, on the edge, clear synchroniser flops, stability, hold and press counters, and all st_o, up_o, dn_o, lp_o to 0.
REQ-028 Reset mid-count or mid-hold SHALL discard progress; no pulse SHALL be emitted on the reset edge or the first edge after release.
REQ-029 After release, a channel whose i[k] is already high SHALL rise after the normal REQ-019 latency and SHALL produce an up_o[k] pulse and press-count increment.

Verification (N=2, STABLE=4, LONG=16, CTR_W=4)
REQ-030 i[0] glitches 0->1 for 3 cycles then 0 -> st_o[0] stays 0, no up_o, cnt 0.
REQ-031 i[0] rises and holds -> st_o[0]=1 and up_o[0] single pulse at edge 6; lp_o[0] one pulse 16 cycles later; cnt=1.
REQ-032 Bouncy edge (1,0,1,1,0,1,1,1,1 ...) -> exactly one up_o[0]; st_o rises 4 cycles after last bounce is synchronised.
REQ-033 17 clean presses on channel 1 -> cnt_o[7:4] saturates at 15; clr[1] pulsed coincident with an up_o[1] -> counter reads 0.
REQ-034 Both channels toggle together -> up_o=2'b11 in the same cycle; channel 0 released after 10 held cycles -> dn_o[0] pulse, no lp_o[0].
REQ-035 rst asserted 2 cycles into a stable high on i[0] -> all outputs 0; after release st_o[0] rises at edge 6 with one up_o pulse.
